// File: rtl/egg_timer_multi_if.sv
// Button/switch and display-side signals of the multi-channel egg timer.
// The board/bench side drives through the master modport and the timer
// core attaches through the slave modport.
interface egg_timer_multi_if #(
    parameter int N_CH = 2
);
    localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;

    // Operator controls
    logic            enable;
    logic [SW-1:0]   sel;
    logic            ButtonModify;
    logic            ButtonStart;
    logic            ButtonMin;
    logic            ButtonSec;
    logic            preset_load;
    logic [1:0]      preset_sel;

    // Display / status
    logic [15:0]     remaining;
    logic [N_CH-1:0] running;
    logic [N_CH-1:0] done;
    logic            led0;
    logic            LED;
    logic            tick;

    modport master (
        output enable, sel, ButtonModify, ButtonStart, ButtonMin, ButtonSec,
               preset_load, preset_sel,
        input  remaining, running, done, led0, LED, tick
    );

    modport slave (
        input  enable, sel, ButtonModify, ButtonStart, ButtonMin, ButtonSec,
               preset_load, preset_sel,
        output remaining, running, done, led0, LED, tick
    );
endinterface

// File: rtl/egg_timer_multi.sv
// Multi-channel mm:ss egg timer core. N_CH independent BCD countdown
// channels share one 1 Hz prescaler and one set of buttons; the buttons,
// preset loads and the display output all address channel sel.
module egg_timer_multi #(
    parameter int          N_CH     = 2,
    parameter int          TICK_DIV = 100000000,
    parameter int          MAX_MIN  = 59,
    parameter logic [15:0] PRESET1  = 16'h0600,
    parameter logic [15:0] PRESET2  = 16'h0930,
    parameter logic [15:0] PRESET3  = 16'h1400
) (
    input logic               CLK100MHZ,
    input logic               reset,
    egg_timer_multi_if.slave  bus
);
    localparam int SW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    // Minute wrap point expressed as two BCD digits
    localparam logic [7:0] MAX_MM = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } ch_state_e;

    // Prescaler and shared strobes
    logic [CW-1:0] cnt_q;
    logic          tick_w;
    logic          led_q;

    // Button history and qualified edges
    logic start_prev, min_prev, sec_prev, load_prev;
    logic start_edge, min_edge, sec_edge, load_edge;

    logic [15:0]   preset_val;

    // Per-channel state
    ch_state_e   state_q  [N_CH];
    ch_state_e   state_d  [N_CH];
    logic [15:0] time_q   [N_CH];
    logic [15:0] time_d   [N_CH];
    logic [15:0] recall_q [N_CH];
    logic [15:0] recall_d [N_CH];

    logic [N_CH-1:0] running_w;
    logic [N_CH-1:0] done_w;
    logic [15:0]     remaining_w;

    // ------------------------------------------------------------------
    // BCD helpers, one decimal digit per nibble
    // ------------------------------------------------------------------
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Seconds edit: 59 wraps to 00 without touching the minutes
    function automatic logic [7:0] sec_step(input logic [7:0] ss);
        if (ss >= 8'h59) return 8'h00;
        return bcd_inc(ss);
    endfunction

    // Minutes edit: MAX_MIN wraps to 00
    function automatic logic [7:0] min_step(input logic [7:0] mm);
        if (mm >= MAX_MM) return 8'h00;
        return bcd_inc(mm);
    endfunction

    // One-second countdown step with borrow from minutes
    function automatic logic [15:0] time_dec(input logic [15:0] t);
        if (t == 16'h0000) return t;
        if (t[7:0] == 8'h00) return {bcd_dec(t[15:8]), 8'h59};
        return {t[15:8], bcd_dec(t[7:0])};
    endfunction

    // ------------------------------------------------------------------
    // Shared 1 Hz prescaler
    // ------------------------------------------------------------------

    // Count 0..TICK_DIV-1 while enabled; hold while disabled
    always_ff @(posedge CLK100MHZ) begin
        // NOTE: every clocked block uses non-blocking assignments so all
        // registers update together from the values sampled at the edge.
        if (reset) begin
            cnt_q <= '0;
        end else if (bus.enable) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    assign tick_w = bus.enable & ~reset & (cnt_q == CNT_LAST);

    // ------------------------------------------------------------------
    // Button edge detection
    // ------------------------------------------------------------------

    // Track previous button levels even while disabled so that a press
    // made during enable=0 is dropped rather than replayed later
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            start_prev <= 1'b0;
            min_prev   <= 1'b0;
            sec_prev   <= 1'b0;
            load_prev  <= 1'b0;
        end else begin
            start_prev <= bus.ButtonStart;
            min_prev   <= bus.ButtonMin;
            sec_prev   <= bus.ButtonSec;
            load_prev  <= bus.preset_load;
        end
    end

    assign start_edge = bus.enable & bus.ButtonStart & ~start_prev;
    assign min_edge   = bus.enable & bus.ButtonMin   & ~min_prev;
    assign sec_edge   = bus.enable & bus.ButtonSec   & ~sec_prev;
    assign load_edge  = bus.enable & bus.preset_load & ~load_prev;

    // Preset value selected by preset_sel
    always_comb begin
        preset_val = 16'h0000;
        case (bus.preset_sel)
            2'd1:    preset_val = PRESET1;
            2'd2:    preset_val = PRESET2;
            2'd3:    preset_val = PRESET3;
            default: preset_val = 16'h0000;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-channel FSM and time arithmetic
    // ------------------------------------------------------------------

    // Next state/time/recall for every channel, highest priority first:
    // preset_load, Start, edit, tick
    always_comb begin
        logic        hit;
        logic [15:0] t;
        for (int i = 0; i < N_CH; i++) begin
            // NOTE: every combinational output gets its hold value first, so
            // no branch can leave it unassigned and infer a latch.
            state_d[i]  = state_q[i];
            time_d[i]   = time_q[i];
            recall_d[i] = recall_q[i];
            t           = time_q[i];
            // An out-of-range sel matches no channel, so its edges are lost
            hit         = (bus.sel == SW'(i));

            if (hit && load_edge && state_q[i] != ST_RUN) begin
                time_d[i]  = preset_val;
                state_d[i] = ST_IDLE;
            end else if (hit && start_edge &&
                         !(state_q[i] == ST_IDLE && time_q[i] == 16'h0000)) begin
                case (state_q[i])
                    ST_IDLE: begin
                        state_d[i]  = ST_RUN;
                        recall_d[i] = time_q[i];
                    end
                    ST_RUN:   state_d[i] = ST_PAUSE;
                    ST_PAUSE: state_d[i] = ST_RUN;
                    ST_DONE: begin
                        state_d[i] = ST_IDLE;
                        time_d[i]  = recall_q[i];
                    end
                    default:  state_d[i] = ST_IDLE;
                endcase
            end else if (hit && bus.ButtonModify && (min_edge || sec_edge) &&
                         (state_q[i] == ST_IDLE || state_q[i] == ST_PAUSE)) begin
                if (sec_edge) t[7:0]  = sec_step(t[7:0]);
                if (min_edge) t[15:8] = min_step(t[15:8]);
                time_d[i] = t;
                // A paused channel edited down to zero has nothing left to run
                if (state_q[i] == ST_PAUSE && t == 16'h0000) state_d[i] = ST_IDLE;
            end else if (tick_w && state_q[i] == ST_RUN) begin
                t         = time_dec(time_q[i]);
                time_d[i] = t;
                if (t == 16'h0000) state_d[i] = ST_DONE;
            end
        end
    end

    // Channel registers
    always_ff @(posedge CLK100MHZ) begin
        // NOTE: these arrays are a handful of flops per channel rather than
        // a RAM, so reset clears them along with the rest of the state.
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]  <= ST_IDLE;
                time_q[i]   <= 16'h0000;
                recall_q[i] <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i]  <= state_d[i];
                time_q[i]   <= time_d[i];
                recall_q[i] <= recall_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    // Status vectors and display mux for channel sel
    always_comb begin
        running_w   = '0;
        done_w      = '0;
        remaining_w = 16'h0000;
        for (int i = 0; i < N_CH; i++) begin
            running_w[i] = (state_q[i] == ST_RUN);
            done_w[i]    = (state_q[i] == ST_DONE);
            if (bus.sel == SW'(i)) remaining_w = time_q[i];
        end
    end

    // Heartbeat LED: toggles each tick while anything runs, else dark
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            led_q <= 1'b0;
        end else if (!(|running_w)) begin
            led_q <= 1'b0;
        end else if (tick_w) begin
            led_q <= ~led_q;
        end
    end

    assign bus.remaining = remaining_w;
    assign bus.running   = running_w;
    assign bus.done      = done_w;
    assign bus.led0      = bus.enable;
    assign bus.LED       = led_q;
    assign bus.tick      = tick_w;
endmodule

// File: tb/tb_egg_timer_multi.sv
// Self-checking bench for egg_timer_multi (N_CH=2, TICK_DIV=4). A
// behavioural model tracks each channel as whole minutes/seconds with
// plain arithmetic and run/pause/done flags.
module tb_egg_timer_multi;
    localparam int N    = 2;
    localparam int TD   = 4;
    localparam int MAXM = 59;

    logic clk = 1'b0;
    logic reset;

    int errors = 0;
    int checks = 0;

    egg_timer_multi_if #(.N_CH(N)) bus ();

    egg_timer_multi #(
        .N_CH(N), .TICK_DIV(TD), .MAX_MIN(MAXM),
        .PRESET1(16'h0600), .PRESET2(16'h0930), .PRESET3(16'h1400)
    ) dut (
        .CLK100MHZ(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int mm_m [N];
    int ss_m [N];
    int rmm_m[N];
    int rss_m[N];
    bit run_m[N];
    bit pause_m[N];
    bit done_m[N];
    int presc_m = 0;
    bit led_m = 0;
    bit pst = 0, pmn = 0, psc = 0, pld = 0;
    int n_ticks = 0;

    function automatic logic [15:0] to_bcd(input int mm, input int ss);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic int preset_secs(input int ps);
        case (ps)
            1:       return 6 * 60;
            2:       return 9 * 60 + 30;
            3:       return 14 * 60;
            default: return 0;
        endcase
    endfunction

    function automatic logic [15:0] exp_rem();
        int s;
        s = int'(bus.sel);
        return to_bcd(mm_m[s], ss_m[s]);
    endfunction

    function automatic logic [N-1:0] exp_running();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = run_m[i];
        return v;
    endfunction

    function automatic logic [N-1:0] exp_done();
        logic [N-1:0] v;
        for (int i = 0; i < N; i++) v[i] = done_m[i];
        return v;
    endfunction

    always @(posedge clk) begin
        bit tk, es, emn, esc, eld, anyrun, idle;
        int tot;
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                mm_m[i] = 0; ss_m[i] = 0; rmm_m[i] = 0; rss_m[i] = 0;
                run_m[i] = 0; pause_m[i] = 0; done_m[i] = 0;
            end
            presc_m = 0; led_m = 0; pst = 0; pmn = 0; psc = 0; pld = 0;
        end else begin
            tk  = bus.enable && (presc_m == TD - 1);
            es  = bus.enable && bus.ButtonStart && !pst;
            emn = bus.enable && bus.ButtonMin   && !pmn;
            esc = bus.enable && bus.ButtonSec   && !psc;
            eld = bus.enable && bus.preset_load && !pld;
            pst = bus.ButtonStart; pmn = bus.ButtonMin;
            psc = bus.ButtonSec;   pld = bus.preset_load;
            anyrun = 0;
            for (int i = 0; i < N; i++) anyrun |= run_m[i];
            if (bus.enable) presc_m = (presc_m == TD - 1) ? 0 : presc_m + 1;
            if (tk) n_ticks++;
            for (int i = 0; i < N; i++) begin
                bit hit;
                hit  = (int'(bus.sel) == i);
                idle = !run_m[i] && !pause_m[i] && !done_m[i];
                tot  = mm_m[i] * 60 + ss_m[i];
                if (hit && eld && !run_m[i]) begin
                    mm_m[i] = preset_secs(int'(bus.preset_sel)) / 60;
                    ss_m[i] = preset_secs(int'(bus.preset_sel)) % 60;
                    pause_m[i] = 0; done_m[i] = 0;
                end else if (hit && es && !(idle && tot == 0)) begin
                    if (idle) begin
                        run_m[i] = 1; rmm_m[i] = mm_m[i]; rss_m[i] = ss_m[i];
                    end else if (run_m[i]) begin
                        run_m[i] = 0; pause_m[i] = 1;
                    end else if (pause_m[i]) begin
                        pause_m[i] = 0; run_m[i] = 1;
                    end else begin
                        done_m[i] = 0; mm_m[i] = rmm_m[i]; ss_m[i] = rss_m[i];
                    end
                end else if (hit && bus.ButtonModify && (emn || esc) && (idle || pause_m[i])) begin
                    if (esc) ss_m[i] = (ss_m[i] + 1) % 60;
                    if (emn) mm_m[i] = (mm_m[i] + 1) % (MAXM + 1);
                    if (pause_m[i] && mm_m[i] == 0 && ss_m[i] == 0) pause_m[i] = 0;
                end else if (tk && run_m[i]) begin
                    tot = tot - 1;
                    mm_m[i] = tot / 60;
                    ss_m[i] = tot % 60;
                    if (tot == 0) begin
                        run_m[i] = 0; done_m[i] = 1;
                    end
                end
            end
            if (!anyrun) led_m = 0;
            else if (tk) led_m = !led_m;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input bit st, input bit mn, input bit sc, input bit ld);
        bus.ButtonStart = st; bus.ButtonMin = mn; bus.ButtonSec = sc; bus.preset_load = ld;
        cyc(1);
        bus.ButtonStart = 0; bus.ButtonMin = 0; bus.ButtonSec = 0; bus.preset_load = 0;
        cyc(1);
    endtask

    task automatic do_reset();
        reset = 1;
        cyc(2);
        reset = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (bus.remaining !== 16'h0000) begin errors++; $display("FAIL reset_remaining: got %h expected 0000", bus.remaining); end
        checks++; if (bus.running !== 2'b00) begin errors++; $display("FAIL reset_running: got %b expected 00", bus.running); end
        checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL reset_done: got %b expected 00", bus.done); end
        checks++; if (bus.LED !== 1'b0) begin errors++; $display("FAIL reset_LED: got %b expected 0", bus.LED); end
        checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b expected 0", bus.tick); end
        checks++; if (bus.led0 !== 1'b1) begin errors++; $display("FAIL reset_led0: got %b expected 1", bus.led0); end
    endtask

    task automatic test_edit();
        bus.sel = 1'b0;
        bus.ButtonModify = 1;
        press(0, 0, 1, 0);
        press(0, 0, 1, 0);
        press(0, 1, 0, 0);
        bus.ButtonModify = 0;
        checks++; if (bus.remaining !== 16'h0102) begin errors++; $display("FAIL edit_remaining: got %h expected 0102", bus.remaining); end
        checks++; if (bus.running !== 2'b00) begin errors++; $display("FAIL edit_running: got %b expected 00", bus.running); end
        checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL edit_done: got %b expected 00", bus.done); end
    endtask

    task automatic test_countdown();
        int n0;
        bit seen3, finished;
        bus.ButtonStart = 1;
        cyc(1);
        checks++; if (bus.running[0] !== 1'b1) begin errors++; $display("FAIL start_running: got %b expected 1", bus.running[0]); end
        bus.ButtonStart = 0;
        n0 = n_ticks;
        seen3 = 0;
        finished = 0;
        for (int c = 0; c < 62 * TD + 20 && !finished; c++) begin
            cyc(1);
            checks++; if (bus.remaining !== exp_rem()) begin errors++; $display("FAIL count_remaining: got %h expected %h", bus.remaining, exp_rem()); end
            checks++; if (bus.LED !== led_m) begin errors++; $display("FAIL count_LED: got %b expected %b", bus.LED, led_m); end
            if (run_m[0]) begin
                checks++; if (bus.LED !== 1'((n_ticks - n0) % 2)) begin errors++; $display("FAIL count_LED_parity: got %b after %0d ticks", bus.LED, n_ticks - n0); end
            end
            if (!seen3 && n_ticks - n0 == 3) begin
                seen3 = 1;
                checks++; if (bus.remaining !== 16'h0059) begin errors++; $display("FAIL count_3ticks: got %h expected 0059", bus.remaining); end
            end
            if (bus.done[0] === 1'b1) begin
                finished = 1;
                checks++; if (n_ticks - n0 != 62) begin errors++; $display("FAIL done_tick_count: got %0d expected 62", n_ticks - n0); end
                checks++; if (bus.remaining !== 16'h0000) begin errors++; $display("FAIL done_remaining: got %h expected 0000", bus.remaining); end
            end
        end
        checks++; if (!finished) begin errors++; $display("FAIL done_timeout: got no done expected done within budget"); end
    endtask

    task automatic test_done_ack();
        bus.ButtonStart = 1;
        cyc(1);
        checks++; if (bus.done[0] !== 1'b0) begin errors++; $display("FAIL ack_done: got %b expected 0", bus.done[0]); end
        checks++; if (bus.running[0] !== 1'b0) begin errors++; $display("FAIL ack_running: got %b expected 0", bus.running[0]); end
        checks++; if (bus.remaining !== 16'h0102) begin errors++; $display("FAIL ack_recall: got %h expected 0102", bus.remaining); end
        checks++; if (bus.LED !== 1'b0) begin errors++; $display("FAIL ack_LED: got %b expected 0", bus.LED); end
        bus.ButtonStart = 0;
        cyc(1);
    endtask

    task automatic test_pause_collision();
        int n1, guard;
        bus.preset_sel = 2'd0;
        press(0, 0, 0, 1);
        bus.ButtonModify = 1;
        repeat (10) press(0, 0, 1, 0);
        bus.ButtonModify = 0;
        checks++; if (bus.remaining !== 16'h0010) begin errors++; $display("FAIL coll_setup: got %h expected 0010", bus.remaining); end
        guard = 0;
        while (presc_m != 0 && guard < 10) begin cyc(1); guard++; end
        bus.ButtonStart = 1;
        cyc(1);
        bus.ButtonStart = 0;
        cyc(1);
        guard = 0;
        while (presc_m != TD - 1 && guard < 10) begin cyc(1); guard++; end
        checks++; if (bus.tick !== 1'b1) begin errors++; $display("FAIL coll_tick_pending: got %b expected 1", bus.tick); end
        bus.ButtonStart = 1;
        cyc(1);
        bus.ButtonStart = 0;
        checks++; if (bus.remaining !== 16'h0010) begin errors++; $display("FAIL coll_remaining: got %h expected 0010", bus.remaining); end
        checks++; if (bus.running[0] !== 1'b0) begin errors++; $display("FAIL coll_running: got %b expected 0", bus.running[0]); end
        bus.enable = 0;
        cyc(5);
        press(1, 0, 0, 0);
        cyc(13);
        checks++; if (bus.remaining !== 16'h0010) begin errors++; $display("FAIL frozen_remaining: got %h expected 0010", bus.remaining); end
        checks++; if (bus.running[0] !== 1'b0) begin errors++; $display("FAIL frozen_running: got %b expected 0", bus.running[0]); end
        checks++; if (bus.led0 !== 1'b0) begin errors++; $display("FAIL frozen_led0: got %b expected 0", bus.led0); end
        checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL frozen_tick: got %b expected 0", bus.tick); end
        bus.enable = 1;
        bus.ButtonStart = 1;
        cyc(1);
        bus.ButtonStart = 0;
        checks++; if (bus.running[0] !== 1'b1) begin errors++; $display("FAIL resume_running: got %b expected 1", bus.running[0]); end
        n1 = n_ticks;
        guard = 0;
        while (n_ticks - n1 < 2 && guard < 4 * TD) begin cyc(1); guard++; end
        checks++; if (bus.remaining !== 16'h0008) begin errors++; $display("FAIL resume_remaining: got %h expected 0008", bus.remaining); end
    endtask

    task automatic test_channels();
        logic [15:0] r0;
        bus.sel = 1'b0;
        bus.preset_sel = 2'd2;
        press(0, 0, 0, 1);
        checks++; if (bus.running[0] !== 1'b1) begin errors++; $display("FAIL load_in_run_state: got %b expected 1", bus.running[0]); end
        checks++; if (bus.remaining !== exp_rem()) begin errors++; $display("FAIL load_in_run_time: got %h expected %h", bus.remaining, exp_rem()); end
        press(1, 0, 0, 0);
        r0 = to_bcd(mm_m[0], ss_m[0]);
        bus.sel = 1'b1;
        bus.preset_sel = 2'd3;
        press(0, 0, 0, 1);
        checks++; if (bus.remaining !== 16'h1400) begin errors++; $display("FAIL ch1_preset: got %h expected 1400", bus.remaining); end
        bus.sel = 1'b0;
        #1;
        checks++; if (bus.remaining !== r0) begin errors++; $display("FAIL ch0_unchanged: got %h expected %h", bus.remaining, r0); end
        bus.sel = 1'b1;
        press(1, 0, 0, 0);
        bus.sel = 1'b0;
        press(1, 0, 0, 0);
        checks++; if (bus.running !== 2'b11) begin errors++; $display("FAIL both_running: got %b expected 11", bus.running); end
        for (int c = 0; c < 40; c++) begin
            bus.sel = 1'($urandom_range(0, 1));
            cyc(1);
            checks++; if (bus.remaining !== exp_rem()) begin errors++; $display("FAIL dual_remaining ch%0d: got %h expected %h", bus.sel, bus.remaining, exp_rem()); end
            checks++; if (bus.running !== exp_running()) begin errors++; $display("FAIL dual_running: got %b expected %b", bus.running, exp_running()); end
            checks++; if (bus.done !== exp_done()) begin errors++; $display("FAIL dual_done: got %b expected %b", bus.done, exp_done()); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            reset            = ($urandom_range(0, 399) == 0);
            bus.enable       = ($urandom_range(0, 15) != 0);
            bus.sel          = 1'($urandom_range(0, 1));
            bus.ButtonModify = 1'($urandom_range(0, 1));
            bus.ButtonStart  = ($urandom_range(0, 5) == 0);
            bus.ButtonMin    = ($urandom_range(0, 7) == 0);
            bus.ButtonSec    = ($urandom_range(0, 3) == 0);
            bus.preset_load  = ($urandom_range(0, 19) == 0);
            bus.preset_sel   = 2'($urandom_range(0, 1) == 0 ? 0 : $urandom_range(0, 3));
            cyc(1);
            checks++; if (bus.remaining !== exp_rem()) begin errors++; $display("FAIL rand_remaining @%0d: got %h expected %h", c, bus.remaining, exp_rem()); end
            checks++; if (bus.running !== exp_running()) begin errors++; $display("FAIL rand_running @%0d: got %b expected %b", c, bus.running, exp_running()); end
            checks++; if (bus.done !== exp_done()) begin errors++; $display("FAIL rand_done @%0d: got %b expected %b", c, bus.done, exp_done()); end
            checks++; if (bus.LED !== led_m) begin errors++; $display("FAIL rand_LED @%0d: got %b expected %b", c, bus.LED, led_m); end
            checks++; if (bus.tick !== (bus.enable && !reset && presc_m == TD - 1)) begin errors++; $display("FAIL rand_tick @%0d: got %b", c, bus.tick); end
        end
        reset = 0;
        bus.enable = 1;
        bus.ButtonStart = 0; bus.ButtonMin = 0; bus.ButtonSec = 0; bus.preset_load = 0;
        bus.ButtonModify = 0;
        cyc(1);
    endtask

    task automatic test_wraps();
        int k;
        do_reset();
        bus.sel = 1'b0;
        press(1, 0, 0, 0);
        checks++; if (bus.running !== 2'b00) begin errors++; $display("FAIL zero_start: got %b expected 00", bus.running); end
        bus.ButtonModify = 1;
        press(0, 1, 0, 0);
        repeat (59) press(0, 0, 1, 0);
        checks++; if (bus.remaining !== 16'h0159) begin errors++; $display("FAIL sec_to_59: got %h expected 0159", bus.remaining); end
        press(0, 0, 1, 0);
        checks++; if (bus.remaining !== 16'h0100) begin errors++; $display("FAIL sec_wrap: got %h expected 0100", bus.remaining); end
        repeat (58) press(0, 1, 0, 0);
        checks++; if (bus.remaining !== 16'h5900) begin errors++; $display("FAIL min_to_59: got %h expected 5900", bus.remaining); end
        press(0, 1, 0, 0);
        checks++; if (bus.remaining !== 16'h0000) begin errors++; $display("FAIL min_wrap: got %h expected 0000", bus.remaining); end
        press(0, 1, 1, 0);
        checks++; if (bus.remaining !== 16'h0101) begin errors++; $display("FAIL both_edges: got %h expected 0101", bus.remaining); end
        bus.ButtonModify = 0;
        press(1, 0, 0, 0);
        cyc(3 * TD);
        checks++; if (bus.running !== 2'b01) begin errors++; $display("FAIL pre_reset_running: got %b expected 01", bus.running); end
        reset = 1;
        cyc(1);
        checks++; if (bus.remaining !== 16'h0000) begin errors++; $display("FAIL midrun_reset_remaining: got %h expected 0000", bus.remaining); end
        checks++; if (bus.running !== 2'b00) begin errors++; $display("FAIL midrun_reset_running: got %b expected 00", bus.running); end
        checks++; if (bus.done !== 2'b00) begin errors++; $display("FAIL midrun_reset_done: got %b expected 00", bus.done); end
        checks++; if (bus.LED !== 1'b0) begin errors++; $display("FAIL midrun_reset_LED: got %b expected 0", bus.LED); end
        reset = 0;
        #1;
        checks++; if (bus.tick !== 1'b0) begin errors++; $display("FAIL post_reset_tick: got %b expected 0", bus.tick); end
        k = 0;
        while (bus.tick !== 1'b1 && k < 4 * TD) begin cyc(1); k++; end
        checks++; if (k != TD - 1) begin errors++; $display("FAIL post_reset_tick_delay: got %0d cycles expected %0d", k, TD - 1); end
    endtask

    initial begin
        reset            = 1;
        bus.enable       = 1;
        bus.sel          = 1'b0;
        bus.ButtonModify = 0;
        bus.ButtonStart  = 0;
        bus.ButtonMin    = 0;
        bus.ButtonSec    = 0;
        bus.preset_load  = 0;
        bus.preset_sel   = 2'd0;
        test_reset();
        test_edit();
        test_countdown();
        test_done_ack();
        test_pause_collision();
        test_channels();
        test_random();
        test_wraps();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/egg_timer_multi.md
Name: egg_timer_multi

Overview:
Parametrised next-generation egg timer core. It holds N_CH independent mm:ss countdown channels that share one 1 Hz tick prescaler and one button interface, addressed by a channel select. Each channel supports pause/resume, preset loading (off/soft/medium/hard), and recall of its last start value after the alarm. The block sits between the debounced board buttons/switches and the 7-segment/LED driver.

Parameters:
N_CH, 2, number of countdown channels (1..8)
TICK_DIV, 100000000, CLK100MHZ cycles per 1 s tick (>=2; benches use 4)
MAX_MIN, 59, maximum programmable minutes (<=99)
PRESET1, 16'h0600, soft-boiled preset, BCD mm:ss
PRESET2, 16'h0930, medium-boiled preset, BCD mm:ss
PRESET3, 16'h1400, hard-boiled preset, BCD mm:ss

Ports:
CLK100MHZ  in  1  single system clock, all logic on its rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  global enable; low freezes prescaler and all channels and ignores buttons
sel  in  max(1,$clog2(N_CH))  channel addressed by the buttons and the display output
ButtonModify  in  1  level; high permits ButtonMin/ButtonSec edits
ButtonStart  in  1  start/pause/acknowledge, acted on at its rising edge
ButtonMin  in  1  minute increment, acted on at its rising edge
ButtonSec  in  1  second increment, acted on at its rising edge
preset_load  in  1  loads preset_sel value, acted on at its rising edge
preset_sel  in  2  0=00:00, 1=PRESET1, 2=PRESET2, 3=PRESET3
remaining  out  16  BCD mm:ss of channel sel
running  out  N_CH  per-channel RUN state
done  out  N_CH  per-channel DONE (alarm) state
led0  out  1  equals enable
LED  out  1  toggles on every tick while any channel is running, else 0
tick  out  1  one-cycle 1 Hz strobe, for the stopwatch block

Behaviour:
- Reset (synchronous): prescaler=0, tick=0, LED=0, button history regs=0, every channel IDLE, time=00:00, recall=00:00. Outputs running=0, done=0, remaining=16'h0000.
- Prescaler: while enable=1, counts 0..TICK_DIV-1; tick=1 for the one cycle when count=TICK_DIV-1, then wraps to 0. enable=0 holds count, tick=0.
- Edge detect: each button input is registered once. An edge is input=1 & prev=0. The resulting state/time change is visible on outputs one clock after the cycle the input is first sampled high. Edges seen while enable=0 are discarded, not queued.
- Buttons, ButtonModify and preset_load affect only channel sel. Ticks affect every RUN channel at once.
- Per-channel FSM (IDLE, RUN, PAUSE, DONE):
  IDLE: Start edge with time!=00:00 -> RUN and recall<=time. Start edge with time=00:00 is ignored.
  RUN: each tick decrements time; a decrement reaching 00:00 -> DONE on the same edge. Start edge -> PAUSE.
  PAUSE: Start edge -> RUN. recall is unchanged.
  DONE: Start edge -> IDLE with time<=recall.
- Edits: allowed only in IDLE/PAUSE with ButtonModify=1.
  Sec edge: ss+1; 59 wraps to 00 with no carry into minutes.
  Min edge: mm+1; MAX_MIN wraps to 00.
  Both edges in the same cycle apply both increments.
  Edits in PAUSE that leave time=00:00 -> IDLE.
- preset_load edge: allowed in IDLE/PAUSE/DONE; time<=preset, state<=IDLE. Ignored in RUN.
- Decrement: ss=00 -> ss=59 and mm-1; otherwise ss-1. All arithmetic is BCD, one digit per nibble.
- Priority within channel sel: reset > preset_load > Start > edit > tick. A Start edge and a tick in the same cycle in RUN: pause wins and no decrement occurs.
- remaining: combinational mux of the registered time for channel sel; it follows sel in the same cycle. An out-of-range sel gives 16'h0000, and button edges for it are ignored.
- LED: registered; toggles on tick while |running, forced to 0 when no channel is running.
- Reset mid-countdown: full reset as above; the next tick is TICK_DIV cycles after reset is released.

Test Plan:
- N_CH=2, TICK_DIV=4: reset, sel=0, ButtonModify=1, 2 Sec edges + 1 Min edge -> remaining=16'h0102, running=0, done=0.
- From 01:02: Start edge -> running[0]=1 one clock later. After 3 ticks remaining=16'h0059; countdown continues to 16'h0000 with done[0]=1 exactly on the 62nd tick; LED toggles each tick until then.
- DONE ack: Start edge with done[0]=1 -> done[0]=0, IDLE, remaining=16'h0102 (recall).
- Pause collision: in RUN at 00:10, Start edge on the same cycle as tick -> PAUSE, remaining stays 16'h0010. Hold enable=0 for 20 cycles, then enable=1 with a Start edge -> remaining decrements resume.
- Channels: sel=1, preset_sel=3, preset_load edge -> channel 1 reads 16'h1400 while channel 0 is unchanged. Start both channels; each tick decrements both independently. preset_load on a RUN channel is ignored.
- Wraps and zero start: ss=59 + Sec edge -> ss=00, mm unchanged. mm=59 + Min edge -> mm=00. Start at 00:00 -> stays IDLE. reset mid-RUN -> all outputs 0 on the next clock.
